// File: rtl/pim_buf_pkg.sv
// Shared types for the PIM buffer arbiter: FSM states, requester IDs, the
// SRAM request record and the address range check.
package pim_buf_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_PIM  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  size;
    logic        write;
  } buf_req_t;

  // Word-aligned base past the end, or any byte-address bit above the decoded field.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input int unsigned depth,
                                             input int unsigned addr_width);
    logic [31:0] word_base;
    word_base = {addr[31:2], 2'b00};
    return (word_base >= depth) || ((addr >> addr_width) != 32'd0);
  endfunction

endpackage

// File: rtl/pim_buffer_arbiter_if.sv
// Request/response/SRAM bundle between the two requesters, the arbiter and
// the buffer; master is the environment side, slave is the arbiter.
interface pim_buffer_arbiter_if;

  logic        i_core_req_valid;
  logic        o_core_req_ready;
  logic [31:0] i_core_addr;
  logic [31:0] i_core_wr_data;
  logic [3:0]  i_core_size;
  logic        i_core_write;
  logic        o_core_rsp_valid;
  logic        o_core_rsp_err;
  logic [31:0] o_core_rd_data;

  logic        i_pim_req_valid;
  logic        o_pim_req_ready;
  logic [31:0] i_pim_addr;
  logic [31:0] i_pim_wr_data;
  logic [3:0]  i_pim_size;
  logic        i_pim_write;
  logic        i_pim_lock;
  logic        o_pim_rsp_valid;
  logic        o_pim_rsp_err;
  logic [31:0] o_pim_rd_data;

  logic [31:0] o_buf_addr;
  logic [31:0] o_buf_wr_data;
  logic [3:0]  o_buf_size;
  logic        o_buf_write;
  logic        o_buf_read;
  logic [31:0] i_buf_rd_data;

  logic [31:0] o_perf_core_stall;
  logic [31:0] o_perf_pim_stall;

  modport master (
    output i_core_req_valid, i_core_addr, i_core_wr_data, i_core_size, i_core_write,
    output i_pim_req_valid, i_pim_addr, i_pim_wr_data, i_pim_size, i_pim_write, i_pim_lock,
    output i_buf_rd_data,
    input  o_core_req_ready, o_core_rsp_valid, o_core_rsp_err, o_core_rd_data,
    input  o_pim_req_ready, o_pim_rsp_valid, o_pim_rsp_err, o_pim_rd_data,
    input  o_buf_addr, o_buf_wr_data, o_buf_size, o_buf_write, o_buf_read,
    input  o_perf_core_stall, o_perf_pim_stall
  );

  modport slave (
    input  i_core_req_valid, i_core_addr, i_core_wr_data, i_core_size, i_core_write,
    input  i_pim_req_valid, i_pim_addr, i_pim_wr_data, i_pim_size, i_pim_write, i_pim_lock,
    input  i_buf_rd_data,
    output o_core_req_ready, o_core_rsp_valid, o_core_rsp_err, o_core_rd_data,
    output o_pim_req_ready, o_pim_rsp_valid, o_pim_rsp_err, o_pim_rd_data,
    output o_buf_addr, o_buf_wr_data, o_buf_size, o_buf_write, o_buf_read,
    output o_perf_core_stall, o_perf_pim_stall
  );

endinterface

// File: rtl/pim_buf_rr2.sv
// Two-way round-robin grant; lock forces the grant to the engine only.
module pim_buf_rr2
  import pim_buf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt
);

  logic last_grant;

  // NOTE: every output gets a default before the branches, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (lock) begin
      gnt[REQ_PIM] = req[REQ_PIM];
    end else if (req == 2'b11) begin
      gnt = (last_grant == REQ_CORE) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_PIM;
    end else if (gnt != 2'b00) begin
      last_grant <= gnt[REQ_PIM] ? REQ_PIM : REQ_CORE;
    end
  end

endmodule

// File: rtl/pim_buffer_arbiter.sv
// Arbiter and access sequencer sharing the single-port PIM buffer between the
// core and the PIM engine. Stall counters exist only with PIM_BUF_ARB_PERF_EN.
module pim_buffer_arbiter
  import pim_buf_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = 28672,
  parameter int unsigned MEM_ADDR_WIDTH = 15
) (
  input logic                 i_clk,
  input logic                 i_rst,
  pim_buffer_arbiter_if.slave bus
);

  arb_state_e state;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       lock_hold;
  logic       accept;
  logic       sel_oob;
  buf_req_t   core_req;
  buf_req_t   pim_req;
  buf_req_t   sel_req;

  logic        rsp_valid;
  logic        rsp_owner;
  logic        rsp_err;
  logic        rsp_write;
  logic        core_rsp;
  logic        pim_rsp;
  logic        rsp_has_data;

  logic [31:0] buf_addr;
  logic [31:0] buf_wr_data;
  logic [3:0]  buf_size;
  logic        buf_write;

  // Requests are masked during reset so no ready can leak out combinationally.
  assign req       = {bus.i_pim_req_valid, bus.i_core_req_valid} & {2{~i_rst}};
  assign lock_hold = (state == LOCKED) && bus.i_pim_lock;

  pim_buf_rr2 u_rr2 (
    .clk  (i_clk),
    .rst  (i_rst),
    .req  (req),
    .lock (lock_hold),
    .gnt  (gnt)
  );

  assign accept   = |gnt;
  assign core_req = '{addr: bus.i_core_addr, wr_data: bus.i_core_wr_data,
                      size: bus.i_core_size, write: bus.i_core_write};
  assign pim_req  = '{addr: bus.i_pim_addr, wr_data: bus.i_pim_wr_data,
                      size: bus.i_pim_size, write: bus.i_pim_write};
  assign sel_req  = gnt[REQ_PIM] ? pim_req : core_req;
  assign sel_oob  = addr_out_of_range(sel_req.addr, MEM_DEPTH, MEM_ADDR_WIDTH);

  always_comb begin
    buf_addr    = 32'd0;
    buf_wr_data = 32'd0;
    buf_size    = 4'd0;
    buf_write   = 1'b0;
    if (accept) begin
      buf_addr    = sel_req.addr;
      buf_wr_data = sel_req.wr_data;
      buf_size    = sel_req.size;
      buf_write   = sel_req.write && !sel_oob;
    end
  end

  assign bus.o_buf_addr    = buf_addr;
  assign bus.o_buf_wr_data = buf_wr_data;
  assign bus.o_buf_size    = buf_size;
  assign bus.o_buf_write   = buf_write;
  assign bus.o_buf_read    = ~buf_write;

  assign bus.o_core_req_ready = gnt[REQ_CORE];
  assign bus.o_pim_req_ready  = gnt[REQ_PIM];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ARB;
      rsp_valid <= 1'b0;
      rsp_owner <= REQ_CORE;
      rsp_err   <= 1'b0;
      rsp_write <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_owner <= gnt[REQ_PIM] ? REQ_PIM : REQ_CORE;
      rsp_err   <= accept && sel_oob;
      rsp_write <= sel_req.write;
      unique case (state)
        ARB:     if (gnt[REQ_PIM] && bus.i_pim_lock) state <= LOCKED;
        LOCKED:  if (!bus.i_pim_lock) state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

  // Read data comes straight from the SRAM Q in the cycle after acceptance.
  assign core_rsp     = rsp_valid && (rsp_owner == REQ_CORE);
  assign pim_rsp      = rsp_valid && (rsp_owner == REQ_PIM);
  assign rsp_has_data = !rsp_err && !rsp_write;

  assign bus.o_core_rsp_valid = core_rsp;
  assign bus.o_core_rsp_err   = core_rsp && rsp_err;
  assign bus.o_core_rd_data   = (core_rsp && rsp_has_data) ? bus.i_buf_rd_data : 32'd0;
  assign bus.o_pim_rsp_valid  = pim_rsp;
  assign bus.o_pim_rsp_err    = pim_rsp && rsp_err;
  assign bus.o_pim_rd_data    = (pim_rsp && rsp_has_data) ? bus.i_buf_rd_data : 32'd0;

`ifdef PIM_BUF_ARB_PERF_EN
  logic [31:0] core_stall;
  logic [31:0] pim_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      core_stall <= 32'd0;
      pim_stall  <= 32'd0;
    end else begin
      if (bus.i_core_req_valid && !gnt[REQ_CORE] && (core_stall != 32'hFFFF_FFFF))
        core_stall <= core_stall + 32'd1;
      if (bus.i_pim_req_valid && !gnt[REQ_PIM] && (pim_stall != 32'hFFFF_FFFF))
        pim_stall <= pim_stall + 32'd1;
    end
  end

  assign bus.o_perf_core_stall = core_stall;
  assign bus.o_perf_pim_stall  = pim_stall;
`else
  assign bus.o_perf_core_stall = 32'd0;
  assign bus.o_perf_pim_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_pim_buffer_arbiter.sv
// Scoreboard bench for pim_buffer_arbiter with a byte-lane SRAM model behind it.
module tb_pim_buffer_arbiter;

  localparam int WORDS = 7168;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  size;
    logic        write;
    logic        lock;
  } stim_t;

  typedef struct {
    logic        owner;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;

  pim_buffer_arbiter_if bus ();

  pim_buffer_arbiter #(
    .MEM_DEPTH      (28672),
    .MEM_ADDR_WIDTH (15)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  stim_t core_stim [64];
  stim_t pim_stim  [64];
  int    core_n = 0;
  int    pim_n  = 0;
  int    core_idx;
  int    pim_idx;
  logic  core_acc;
  logic  pim_acc;

  exp_t  exp_q[$];
  logic  grant_log[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h0001_0203) ^ 32'hA5C3_0000;
  endfunction

  function automatic logic tb_oob(input logic [31:0] addr);
    return ((addr & 32'hFFFF_FFFC) >= 32'd28672) || (addr[31:15] != 17'd0);
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < grant_log.size()) return 32'(grant_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  // SRAM model: request sampled mid-cycle, applied on the rising edge.
  initial begin : sram
    logic [31:0] mem [WORDS];
    logic        s_wr, s_rd;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_size;
    int          idx;
    for (int i = 0; i < WORDS; i++) mem[i] = init_word(i);
    bus.i_buf_rd_data = 32'd0;
    forever begin
      @(negedge clk);
      s_wr = bus.o_buf_write; s_rd = bus.o_buf_read;
      s_addr = bus.o_buf_addr; s_data = bus.o_buf_wr_data; s_size = bus.o_buf_size;
      @(posedge clk);
      idx = int'(s_addr[14:2]);
      if (s_wr) begin
        if (idx < WORDS)
          for (int b = 0; b < 4; b++)
            if (s_size[b]) mem[idx][8*b +: 8] = s_data[8*b +: 8];
      end else if (s_rd) begin
        bus.i_buf_rd_data = (idx < WORDS) ? mem[idx] : 32'hDEAD_BEEF;
      end
    end
  end

  initial begin : core_drv
    stim_t r;
    core_idx = 0;
    bus.i_core_req_valid = 1'b0; bus.i_core_addr = 32'd0;
    bus.i_core_wr_data = 32'd0; bus.i_core_size = 4'd0; bus.i_core_write = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.i_core_req_valid = 1'b0;
      end else begin
        if (core_acc) bus.i_core_req_valid = 1'b0;
        if (!bus.i_core_req_valid && core_idx < core_n) begin
          r = core_stim[core_idx];
          core_idx++;
          bus.i_core_addr = r.addr; bus.i_core_wr_data = r.data;
          bus.i_core_size = r.size; bus.i_core_write = r.write;
          bus.i_core_req_valid = 1'b1;
        end
      end
    end
  end

  initial begin : pim_drv
    stim_t r;
    pim_idx = 0;
    bus.i_pim_req_valid = 1'b0; bus.i_pim_addr = 32'd0; bus.i_pim_lock = 1'b0;
    bus.i_pim_wr_data = 32'd0; bus.i_pim_size = 4'd0; bus.i_pim_write = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.i_pim_req_valid = 1'b0;
        bus.i_pim_lock = 1'b0;
      end else begin
        if (pim_acc) begin
          bus.i_pim_req_valid = 1'b0;
          bus.i_pim_lock = 1'b0;
        end
        if (!bus.i_pim_req_valid && pim_idx < pim_n) begin
          r = pim_stim[pim_idx];
          pim_idx++;
          bus.i_pim_addr = r.addr; bus.i_pim_wr_data = r.data;
          bus.i_pim_size = r.size; bus.i_pim_write = r.write; bus.i_pim_lock = r.lock;
          bus.i_pim_req_valid = 1'b1;
        end
      end
    end
  end

  // Monitor: checks the response due this cycle, then scores any new accept.
  initial begin : monitor
    logic [31:0] shadow [WORDS];
    exp_t        e;
    logic        cacc, pacc, oob, owner, wr;
    logic [31:0] addr, data;
    logic [3:0]  size;
    int          idx;
    for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
    core_acc = 1'b0; pim_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        core_acc = 1'b0; pim_acc = 1'b0;
      end else begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("core_rsp_valid", bus.o_core_rsp_valid, e.owner == 1'b0);
          check("pim_rsp_valid", bus.o_pim_rsp_valid, e.owner == 1'b1);
          if (e.owner == 1'b0) begin
            check("core_rsp_err", bus.o_core_rsp_err, e.err);
            check("core_rd_data", bus.o_core_rd_data, e.data);
          end else begin
            check("pim_rsp_err", bus.o_pim_rsp_err, e.err);
            check("pim_rd_data", bus.o_pim_rd_data, e.data);
          end
        end else begin
          check("core_rsp_idle", bus.o_core_rsp_valid, 0);
          check("pim_rsp_idle", bus.o_pim_rsp_valid, 0);
        end

        cacc = bus.i_core_req_valid && bus.o_core_req_ready;
        pacc = bus.i_pim_req_valid && bus.o_pim_req_ready;
        check("single_grant", 32'(cacc && pacc), 0);
        check("core_ready_only_if_valid", 32'(bus.o_core_req_ready && !bus.i_core_req_valid), 0);
        check("pim_ready_only_if_valid", 32'(bus.o_pim_req_ready && !bus.i_pim_req_valid), 0);

        if (cacc || pacc) begin
          owner = pacc;
          addr  = pacc ? bus.i_pim_addr    : bus.i_core_addr;
          data  = pacc ? bus.i_pim_wr_data : bus.i_core_wr_data;
          size  = pacc ? bus.i_pim_size    : bus.i_core_size;
          wr    = pacc ? bus.i_pim_write   : bus.i_core_write;
          oob   = tb_oob(addr);
          idx   = int'(addr[14:2]);
          check("buf_addr", bus.o_buf_addr, addr);
          check("buf_size", bus.o_buf_size, size);
          check("buf_write", bus.o_buf_write, wr && !oob);
          check("buf_read", bus.o_buf_read, !(wr && !oob));
          if (wr && !oob) check("buf_wr_data", bus.o_buf_wr_data, data);
          e.owner = owner;
          e.err   = oob;
          e.data  = (!oob && !wr) ? shadow[idx] : 32'd0;
          if (!oob && wr)
            for (int b = 0; b < 4; b++)
              if (size[b]) shadow[idx][8*b +: 8] = data[8*b +: 8];
          exp_q.push_back(e);
          grant_log.push_back(owner);
        end else begin
          check("idle_buf_write", bus.o_buf_write, 0);
          check("idle_buf_read", bus.o_buf_read, 1);
          check("idle_buf_size", bus.o_buf_size, 0);
        end
        core_acc = cacc;
        pim_acc  = pacc;
      end
    end
  end

  task automatic push_core(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] size, input logic write);
    core_stim[core_n] = '{addr: addr, data: data, size: size, write: write, lock: 1'b0};
    core_n++;
  endtask

  task automatic push_pim(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] size, input logic write, input logic lock);
    pim_stim[pim_n] = '{addr: addr, data: data, size: size, write: write, lock: lock};
    pim_n++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((core_idx < core_n || pim_idx < pim_n || bus.i_core_req_valid ||
            bus.i_pim_req_valid || exp_q.size() != 0) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(n >= 300), 0);
    @(negedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_ready"}, bus.o_core_req_ready, 0);
    check({tag, "_pim_ready"}, bus.o_pim_req_ready, 0);
    check({tag, "_core_rsp_valid"}, bus.o_core_rsp_valid, 0);
    check({tag, "_pim_rsp_valid"}, bus.o_pim_rsp_valid, 0);
    check({tag, "_core_err"}, bus.o_core_rsp_err, 0);
    check({tag, "_pim_err"}, bus.o_pim_rsp_err, 0);
    check({tag, "_core_rd_data"}, bus.o_core_rd_data, 0);
    check({tag, "_pim_rd_data"}, bus.o_pim_rd_data, 0);
    check({tag, "_buf_write"}, bus.o_buf_write, 0);
    check({tag, "_perf_core"}, bus.o_perf_core_stall, 0);
    check({tag, "_perf_pim"}, bus.o_perf_pim_stall, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          base;
    logic [31:0] stall0_core, stall0_pim;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk); #1;

    // Both stream writes unlocked: strict alternation starting with the core.
    base = grant_log.size();
    for (int i = 0; i < 6; i++) begin
      push_core(32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b1);
      push_pim(32'h400 + 32'(4 * i), 32'hBEEF_0000 + 32'(i), 4'hF, 1'b1, 1'b0);
    end
    wait_idle();
    check("alt_count", 32'(grant_log.size() - base), 12);
    for (int i = 0; i < 12; i++) check("alt_order", log_at(base + i), 32'(i % 2));

    // Lone core read, then read-back of data written by both requesters.
    base = grant_log.size();
    push_core(32'h100, 32'd0, 4'hF, 1'b0);
    wait_idle();
    check("lone_core_grant", log_at(base), 0);
    push_pim(32'h204, 32'd0, 4'hF, 1'b0, 1'b0);
    push_core(32'h408, 32'd0, 4'hF, 1'b0);
    wait_idle();

    // Engine burst under lock while the core waits.
    push_core(32'h104, 32'd0, 4'hF, 1'b0);
    wait_idle();
    base = grant_log.size();
    stall0_core = bus.o_perf_core_stall;
    stall0_pim  = bus.o_perf_pim_stall;
    push_core(32'h208, 32'd0, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++)
      push_pim(32'h600 + 32'(4 * i), 32'h1234_5600 + 32'(i), 4'hF, 1'b1, 1'b1);
    wait_idle();
    for (int i = 0; i < 4; i++) check("lock_pim_grant", log_at(base + i), 1);
    check("lock_release_core", log_at(base + 4), 0);
`ifdef PIM_BUF_ARB_PERF_EN
    check("perf_core_stall", bus.o_perf_core_stall - stall0_core, 4);
    check("perf_pim_stall", bus.o_perf_pim_stall - stall0_pim, 0);
`else
    check("perf_core_off", bus.o_perf_core_stall, 0);
    check("perf_pim_off", bus.o_perf_pim_stall, 0);
`endif
    push_pim(32'h60C, 32'd0, 4'hF, 1'b0, 1'b0);
    wait_idle();

    // Out-of-range accesses and the last valid word.
    push_core(32'h7000, 32'd0, 4'hF, 1'b0);
    push_core(32'h7000, 32'hFFFF_FFFF, 4'hF, 1'b1);
    push_core(32'h6FFC, 32'd0, 4'hF, 1'b0);
    push_pim(32'h0001_0020, 32'h5555_5555, 4'hF, 1'b1, 1'b0);
    push_pim(32'h8000_0000, 32'd0, 4'hF, 1'b0, 1'b0);
    wait_idle();

    // Byte-lane write: only byte 1 of word 0x20 changes.
    push_core(32'h20, 32'd0, 4'hF, 1'b0);
    push_core(32'h20, 32'hAABB_CCDD, 4'b0010, 1'b1);
    push_core(32'h20, 32'd0, 4'hF, 1'b0);
    wait_idle();

    // Reset during the response cycle drops the response.
    push_core(32'h40, 32'd0, 4'hF, 1'b0);
    @(posedge clk); @(negedge clk); #1;
    check("pre_reset_accept", 32'(core_acc), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    base = grant_log.size();
    push_core(32'h300, 32'h0BAD_F00D, 4'hF, 1'b1);
    push_pim(32'h304, 32'hFEED_FACE, 4'hF, 1'b1, 1'b0);
    wait_idle();
    check("post_reset_first_grant", log_at(base), 0);
    check("post_reset_second_grant", log_at(base + 1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pim_buffer_arbiter.md
# pim_buffer_arbiter

Two-port arbiter and access sequencer for the 28 KB PIM buffer SRAM. It shares the single-port synchronous buffer between the RISC-V core data port (requester 0) and the PIM compute engine (requester 1). It uses round-robin arbitration, an optional engine burst lock, and out-of-range rejection. It sits directly in front of `pim_buffer` and drives its `i_buf_*` inputs.

## Interface
- `MEM_DEPTH`, 28672: buffer size in bytes.
- `MEM_ADDR_WIDTH`, 15: byte-address bits decoded by the buffer.
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_core_req_valid` / `i_pim_req_valid` in 1: request valid.
- `o_core_req_ready` / `o_pim_req_ready` out 1: request accepted this cycle.
- `i_core_addr` / `i_pim_addr` in 32: byte address.
- `i_core_wr_data` / `i_pim_wr_data` in 32: write data.
- `i_core_size` / `i_pim_size` in 4: byte-lane enables.
- `i_core_write` / `i_pim_write` in 1: 1 = write, 0 = read.
- `i_pim_lock` in 1: the engine holds the grant while this is high.
- `o_core_rsp_valid` / `o_pim_rsp_valid` out 1: response valid.
- `o_core_rsp_err` / `o_pim_rsp_err` out 1: access was out of range.
- `o_core_rd_data` / `o_pim_rd_data` out 32: read data.
- `o_buf_addr` out 32, `o_buf_wr_data` out 32, `o_buf_size` out 4: SRAM request fields.
- `o_buf_write` out 1: SRAM write strobe.
- `o_buf_read` out 1: driven high on every non-write cycle.
- `i_buf_rd_data` in 32: SRAM Q.
- `o_perf_core_stall` / `o_perf_pim_stall` out 32: stall counters (see Configuration).

## Operation
- A request is accepted on the cycle where valid and ready are both high. At most one acceptance occurs per cycle, and ready is asserted to the granted requester only.
- FSM states:
  - `ARB`: round-robin between the two requesters. `last_grant` resets to 1, so the core wins the first tie. A lone requester wins immediately.
  - `LOCKED`: only the engine is granted.
  - `ARB`→`LOCKED` when the engine is accepted with `i_pim_lock`=1.
  - `LOCKED`→`ARB` on the first cycle with `i_pim_lock`=0. That cycle arbitrates normally, with `last_grant`=1.
- Range check: a request is out of range when `addr[31:2]*4 >= MEM_DEPTH` or `addr[31:MEM_ADDR_WIDTH] != 0`.
  - It is accepted and consumes a grant slot.
  - `o_buf_write`=0 and `o_buf_read`=1 for that access.
  - The response carries `rsp_err`=1 and `rd_data`=0.
- Writes and in-range reads both return exactly one response. A write response has `rd_data`=0.
- The SRAM path is a direct combinational mux of the granted request. When no request is accepted: `o_buf_write`=0, `o_buf_read`=1, `o_buf_size`=0.

## Timing
- Response latency is exactly 1 cycle after acceptance. A registered `rsp_owner`/`rsp_err`/`rsp_valid` stage selects `i_buf_rd_data` for the owner.
- The response is presented for exactly one cycle. There is no response back-pressure: requesters must sink every response.
- Back-to-back accepts are allowed every cycle, giving full throughput.
- Reset values:
  - All `rsp_valid`, `rsp_err` and ready outputs are 0.
  - `rd_data` is 0.
  - FSM is in `ARB`, `last_grant`=1.
  - Perf counters are 0.
- Reset asserted mid-access drops the pending response; no response is issued after reset deasserts.
- A request with valid=1 must hold its fields stable until it is accepted.

## Configuration
- `PIM_BUF_ARB_PERF_EN` defined:
  - Each 32-bit counter increments once per cycle in which that requester has valid=1 and ready=0.
  - Counters saturate at 0xFFFF_FFFF.
- Macro undefined: the counters are not instantiated and both perf outputs are tied to 0.

## Structure
- `pim_buf_pkg`: `arb_state_e` {`ARB`, `LOCKED`}, the requester-ID constants `REQ_CORE`=0 and `REQ_PIM`=1, and the `buf_req_t` struct (addr, wr_data, size, write).
- One sub-module, `pim_buf_rr2`: a 2-way round-robin grant with a `last_grant` register and a lock-override input.

## Test plan
- Core reads 0x100 while the engine is idle → accepted in cycle 0; `o_core_rsp_valid`=1 with the SRAM word in cycle 1; `o_buf_read`=1.
- Both requesters write continuously, engine with `i_pim_lock`=0 → grants alternate core, engine, core, …, starting with the core after reset.
- Engine issues 4 writes with `i_pim_lock`=1 while the core is waiting → 4 consecutive engine grants; the core is granted in the first cycle after lock drops. With perf enabled, `o_perf_core_stall`=4.
- Core reads 0x7000 (28672) → `rsp_err`=1, `rd_data`=0, no SRAM write; the next request to 0x6FFC succeeds.
- Byte write with size=4'b0010 to 0x20, then a read of 0x20 → `o_buf_size`=0010 on the write cycle; only byte 1 of the read data changes.
- Reset asserted the cycle after an accept → no `rsp_valid`; all outputs 0; the first grant after reset goes to the core.
